// File: rtl/bus_ep_pkg.sv
// Shared definitions for the bus FIFO endpoint: ID field geometry,
// broadcast ID, destination extraction helper and counter types.
package bus_ep_pkg;

    localparam int unsigned ID_W      = 8;
    localparam logic [7:0]  BCST_ID   = 8'hFF;
    localparam int unsigned PKT_MAX_W = 64;

    typedef logic [15:0] drop_cnt_t;

    // Destination ID lives in the top ID_W bits of a pckg_sz-wide packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned pckg_sz);
        return ID_W'(pkt >> (pckg_sz - ID_W));
    endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// Show-ahead synchronous FIFO. Same-cycle read and write are allowed
// while full; the head reads as zero while empty.
module ep_sync_fifo
    import bus_ep_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_fifo_endpoint.sv
// Device-side bus endpoint: TX FIFO towards the bus driver, RX FIFO
// from the bus driver with destination-ID filtering.
// Optional feature macro: EP_ADDR_FILTER_EN (enables the ID filter and
// the drop counter; otherwise every push is accepted).
module bus_fifo_endpoint
    import bus_ep_pkg::*;
#(
    parameter int unsigned PCKG_SZ = 16,
    parameter int unsigned DEPTH   = 8,
    parameter logic [7:0]  ID      = 8'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   bus_pndng,
    input  logic                   bus_pop,
    output logic [PCKG_SZ-1:0]     bus_d_pop,
    input  logic                   bus_push,
    input  logic [PCKG_SZ-1:0]     bus_d_push,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [PCKG_SZ-1:0]     tx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [PCKG_SZ-1:0]     rx_data,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   rx_ovf,
    output logic                   pop_unf,
    output logic [15:0]            rx_drop_cnt
);

    logic tx_full;
    logic tx_empty;
    logic tx_wr;
    logic rx_full;
    logic rx_empty;
    logic rx_rd;
    logic rx_wr;
    logic accept;

    // A full TX refuses writes even when popped in the same cycle.
    assign tx_ready  = !tx_full;
    assign tx_wr     = tx_valid && tx_ready;
    assign bus_pndng = !tx_empty;

    assign rx_valid  = !rx_empty;
    assign rx_rd     = rx_valid && rx_ready;
    assign rx_wr     = bus_push && accept;

    ep_sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (bus_pop),
        .rd_data (bus_d_pop),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    ep_sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (bus_d_push),
        .rd_en   (rx_rd),
        .rd_data (rx_data),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

`ifdef EP_ADDR_FILTER_EN
    logic [ID_W-1:0] dest;
    drop_cnt_t       drop_cnt;

    assign dest        = dest_of(PKT_MAX_W'(bus_d_push), PCKG_SZ);
    assign accept      = (dest == ID) || (dest == BCST_ID);
    assign rx_drop_cnt = drop_cnt;

    // Saturating count of pushes rejected on destination mismatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (bus_push && !accept && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign accept      = 1'b1;
    assign rx_drop_cnt = '0;
`endif

    // Sticky error flags: RX overflow loss and TX underflow pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ovf  <= 1'b0;
            pop_unf <= 1'b0;
        end else begin
            if (rx_wr && rx_full && !rx_ready) begin
                rx_ovf <= 1'b1;
            end
            if (bus_pop && tx_empty) begin
                pop_unf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_fifo_endpoint.md
Name: bus_fifo_endpoint

Overview:
- Device-side terminal for one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- Presents the pndng/pop/D_pop interface that the bus driver reads, and sinks the push/D_push interface that the bus driver writes.
- Contains a TX FIFO (user to bus) and an RX FIFO (bus to user), with destination-ID checking on received packets.
- One instance per bus port (DRVS instances) replaces the bench-side FIFO model in synthesizable systems.

Parameters:
- PCKG_SZ, 16, packet width in bits; bits [PCKG_SZ-1:PCKG_SZ-8] carry the destination ID.
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- ID, 0, this endpoint's 8-bit bus ID.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- bus_pndng  out  1  TX FIFO not empty.
- bus_pop  in  1  bus driver consumes the head of the TX FIFO.
- bus_d_pop  out  PCKG_SZ  TX head data.
- bus_push  in  1  bus driver delivers a packet.
- bus_d_push  in  PCKG_SZ  delivered packet.
- tx_valid  in  1  user offers a packet.
- tx_ready  out  1  TX FIFO can accept.
- tx_data  in  PCKG_SZ  user packet.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  user consumes the RX head.
- rx_data  out  PCKG_SZ  RX head data.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- rx_ovf  out  1  sticky: accepted packet lost because RX was full.
- pop_unf  out  1  sticky: bus_pop asserted while TX was empty.
- rx_drop_cnt  out  16  count of packets dropped on address mismatch.

Behaviour:
- Reset (async assert, release sampled on clk): all pointers and counts 0; bus_pndng=0, bus_d_pop=0, rx_valid=0, rx_data=0, tx_ready=1, rx_ovf=0, pop_unf=0, rx_drop_cnt=0. Reset mid-operation discards all FIFO contents immediately.
- Both FIFOs are show-ahead. Data outputs are driven from registered storage; they read 0 while empty.
- TX write:
  - tx_ready = (tx_count != DEPTH).
  - Write occurs at a posedge with tx_valid && tx_ready.
  - bus_pndng rises in the cycle after the write (1-cycle latency).
- TX read:
  - bus_pop at a posedge while non-empty advances the head; the next head (or 0) is visible the following cycle.
  - bus_pop while empty is ignored and sets pop_unf.
- TX simultaneous write and pop: both take effect; count is unchanged. tx_ready is not a pass-through, so a full FIFO still refuses a write even when popped in the same cycle.
- RX accept rule: a push is accepted when dest == ID or dest == 8'hFF (broadcast).
  - A non-matching push is dropped and increments rx_drop_cnt, saturating at 16'hFFFF.
- RX write:
  - Every accepted push is written unless RX is full and rx_ready is not consuming in that cycle.
  - In that case the packet is lost and rx_ovf is set.
  - If RX is full and rx_ready consumes in the same cycle, the push is accepted and the count stays at DEPTH.
- RX read: rx_valid rises the cycle after an accepted push. A pop happens on rx_valid && rx_ready at a posedge.
- Pointers wrap modulo DEPTH. Counts cover 0..DEPTH inclusive.
- There is no bus-side backpressure: the bus driver never sees a full condition.

Optional Feature:
- Macro: EP_ADDR_FILTER_EN.
- Defined: the destination-ID filter is active as described under Behaviour.
- Undefined: every push is treated as accepted, and rx_drop_cnt is tied to 0.

Decomposition:
- Package bus_ep_pkg:
  - localparam ID_W=8.
  - localparam BCST_ID=8'hFF.
  - function dest_of(pkt, PCKG_SZ) returning the top ID_W bits.
  - typedef for count width.
- Sub-module ep_sync_fifo (parameters WIDTH, DEPTH):
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Same-cycle read+write allowed when full.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset then tx_valid with tx_data=16'h03A5 -> next cycle bus_pndng=1 and bus_d_pop=16'h03A5. bus_pop for 1 cycle -> bus_pndng=0, bus_d_pop=0, tx_count=0.
- Write 8 packets (0x0100..0x0107) -> tx_ready=0 after the 8th. A 9th tx_valid is ignored. 8 pops return 0x0100..0x0107 in order.
- ID=2: push 16'h02AA, 16'hFF55, 16'h0711 -> rx_count=2, rx_data sequence 02AA then FF55, rx_drop_cnt=1. With EP_ADDR_FILTER_EN undefined -> rx_count=3, rx_drop_cnt=0.
- Fill RX to 8 with rx_ready=0, then push a 9th matching packet -> rx_ovf=1, rx_count=8. Repeat with rx_ready=1 in the push cycle -> rx_ovf stays 0, count stays 8.
- bus_pop while TX is empty -> pop_unf=1, count stays 0. Assert reset asynchronously with 3 entries held in each FIFO -> all outputs return to reset values before the next posedge.
